// File: rtl/clock_pkg.sv
// Shared definitions for the alarm clock blocks: BCD field widths, the
// alarm FSM state type and a helper that packs a BCD hh:mm time.
package clock_pkg;

  localparam int HOUR_T_W = 2;   // hours, tens digit (0..2)
  localparam int HOUR_U_W = 4;   // hours, units digit (0..9)
  localparam int MIN_T_W  = 3;   // minutes, tens digit (0..5)
  localparam int MIN_U_W  = 4;   // minutes, units digit (0..9)
  localparam int TIME_W   = HOUR_T_W + HOUR_U_W + MIN_T_W + MIN_U_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } alarm_state_e;

  typedef struct packed {
    logic [HOUR_T_W-1:0] hour_t;
    logic [HOUR_U_W-1:0] hour_u;
    logic [MIN_T_W-1:0]  min_t;
    logic [MIN_U_W-1:0]  min_u;
  } bcd_time_t;

  function automatic bcd_time_t bcd_join(
    input logic [HOUR_T_W-1:0] hour_t,
    input logic [HOUR_U_W-1:0] hour_u,
    input logic [MIN_T_W-1:0]  min_t,
    input logic [MIN_U_W-1:0]  min_u
  );
    bcd_time_t t;
    t.hour_t = hour_t;
    t.hour_u = hour_u;
    t.min_t  = min_t;
    t.min_u  = min_u;
    return t;
  endfunction

endpackage

// File: rtl/alarm_match_if.sv
// Bundle of time/alarm inputs, button pulses and the registered alarm outputs
// exchanged between the alarm_match wrapper and its core.
interface alarm_match_if;
  import clock_pkg::*;

  logic      sec_en;
  bcd_time_t now_time;
  bcd_time_t alm_time;
  logic      alarm_on;
  logic      stop_btn;
  logic      snooze_btn;
  logic      buzz;
  logic      ringing;
  logic      snoozing;

  modport master (
    output sec_en, now_time, alm_time, alarm_on, stop_btn, snooze_btn,
    input  buzz, ringing, snoozing
  );

  modport slave (
    input  sec_en, now_time, alm_time, alarm_on, stop_btn, snooze_btn,
    output buzz, ringing, snoozing
  );

endinterface

// File: rtl/alarm_match_core.sv
// Alarm FSM: rising-edge time/alarm match starts RING; stop, switch-off,
// timeout and (with ALARM_SNOOZE_EN defined) snooze handling.
module alarm_match_core
  import clock_pkg::*;
#(
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_SEC = 300
) (
  input  logic         clk,
  input  logic         rst_n,
  alarm_match_if.slave bus
);

  alarm_state_e state_q;
  alarm_state_e state_d;
  logic         buzz_q;
  logic         buzz_d;
  logic         ringing_q;
  logic         match_q;
  logic         match;
  logic         trigger;
  logic         ring_tc;

  assign match   = (bus.now_time == bus.alm_time);
  // Only the first clock of a match minute may ring; match_q resets high so
  // releasing reset inside the alarm minute stays silent.
  assign trigger = match & ~match_q & bus.alarm_on;

  // Counters are held clear outside their own state, so every entry starts at 0.
  sec_counter #(
    .MODULUS (RING_SEC)
  ) u_ring_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q != RING),
    .en    (bus.sec_en),
    .tc    (ring_tc)
  );

`ifdef ALARM_SNOOZE_EN
  logic snooze_tc;
  logic snoozing_q;

  sec_counter #(
    .MODULUS (SNOOZE_SEC)
  ) u_snooze_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q != SNOOZE),
    .en    (bus.sec_en),
    .tc    (snooze_tc)
  );

  assign bus.snoozing = snoozing_q;
`else
  logic unused_snooze;

  assign unused_snooze = bus.snooze_btn ^ (SNOOZE_SEC == 0);
  assign bus.snoozing  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    buzz_d  = buzz_q;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = RING;
          buzz_d  = 1'b1;
        end
      end
      RING: begin
        // Stop beats snooze; a new trigger while ringing is ignored.
        if (bus.stop_btn || !bus.alarm_on) begin
          state_d = IDLE;
          buzz_d  = 1'b0;
`ifdef ALARM_SNOOZE_EN
        end else if (bus.snooze_btn) begin
          state_d = SNOOZE;
          buzz_d  = 1'b0;
`endif
        end else if (bus.sec_en) begin
          if (ring_tc) begin
            state_d = IDLE;
            buzz_d  = 1'b0;
          end else begin
            buzz_d = ~buzz_q;
          end
        end
      end
`ifdef ALARM_SNOOZE_EN
      SNOOZE: begin
        if (bus.stop_btn || !bus.alarm_on) begin
          state_d = IDLE;
          buzz_d  = 1'b0;
        end else if (trigger || (bus.sec_en && snooze_tc)) begin
          state_d = RING;
          buzz_d  = 1'b1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        buzz_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      buzz_q     <= 1'b0;
      ringing_q  <= 1'b0;
      match_q    <= 1'b1;
`ifdef ALARM_SNOOZE_EN
      snoozing_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      buzz_q     <= buzz_d;
      ringing_q  <= (state_d == RING);
      match_q    <= match;
`ifdef ALARM_SNOOZE_EN
      snoozing_q <= (state_d == SNOOZE);
`endif
    end
  end

  assign bus.buzz    = buzz_q;
  assign bus.ringing = ringing_q;

endmodule

// File: rtl/sec_counter.sv
// Modulo-MODULUS seconds counter: advances on en, synchronous clear has
// priority, tc flags the last count (MODULUS-1).
module sec_counter #(
  parameter int unsigned MODULUS = 60
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  // A modulus of 1 would give a zero-width counter; keep at least one bit.
  localparam int unsigned CNT_W = (MODULUS > 1) ? $clog2(MODULUS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MODULUS - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alarm_match.sv
// Alarm clock match/ring controller top. Snooze support is compiled in only
// when ALARM_SNOOZE_EN is defined; the port list is the same either way.
module alarm_match
  import clock_pkg::*;
#(
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_SEC = 300
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                SEC_EN,
  input  logic [HOUR_T_W-1:0] HOUR_2,
  input  logic [HOUR_U_W-1:0] HOUR_10,
  input  logic [MIN_T_W-1:0]  MIN_6,
  input  logic [MIN_U_W-1:0]  MIN_10,
  input  logic [HOUR_T_W-1:0] ALM_2,
  input  logic [HOUR_U_W-1:0] ALM_10,
  input  logic [MIN_T_W-1:0]  ALM_M6,
  input  logic [MIN_U_W-1:0]  ALM_M10,
  input  logic                ALARM_ON,
  input  logic                STOP_BTN,
  input  logic                SNOOZE_BTN,
  output logic                BUZZ,
  output logic                RINGING,
  output logic                SNOOZING
);

  alarm_match_if bus ();

  assign bus.sec_en     = SEC_EN;
  assign bus.now_time   = bcd_join(HOUR_2, HOUR_10, MIN_6, MIN_10);
  assign bus.alm_time   = bcd_join(ALM_2, ALM_10, ALM_M6, ALM_M10);
  assign bus.alarm_on   = ALARM_ON;
  assign bus.stop_btn   = STOP_BTN;
  assign bus.snooze_btn = SNOOZE_BTN;

  alarm_match_core #(
    .RING_SEC   (RING_SEC),
    .SNOOZE_SEC (SNOOZE_SEC)
  ) u_core (
    .clk   (CLK),
    .rst_n (RESET_N),
    .bus   (bus)
  );

  assign BUZZ     = bus.buzz;
  assign RINGING  = bus.ringing;
  assign SNOOZING = bus.snoozing;

endmodule

// File: tb/tb_alarm_match.sv
// Randomised self-checking bench for alarm_match against a minute/second
// level reference model; follows ALARM_SNOOZE_EN the same way as the design.
module tb_alarm_match;
  import clock_pkg::*;

  localparam int RING_SEC   = 60;
  localparam int SNOOZE_SEC = 300;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNOOZE_BUILD = 1'b1;
`else
  localparam bit SNOOZE_BUILD = 1'b0;
`endif

  typedef enum int {M_IDLE, M_RING, M_SNOOZE} mode_t;

  logic CLK;
  logic RESET_N;
  logic buzz;
  logic ringing;
  logic snoozing;

  alarm_match_if tb_bus ();

  int n_cmp = 0;
  int n_bad = 0;

  mode_t m_mode;
  int    m_ring_secs;
  int    m_snz_secs;
  bit    m_prev_match;

  alarm_match #(
    .RING_SEC   (RING_SEC),
    .SNOOZE_SEC (SNOOZE_SEC)
  ) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .SEC_EN     (tb_bus.sec_en),
    .HOUR_2     (tb_bus.now_time.hour_t),
    .HOUR_10    (tb_bus.now_time.hour_u),
    .MIN_6      (tb_bus.now_time.min_t),
    .MIN_10     (tb_bus.now_time.min_u),
    .ALM_2      (tb_bus.alm_time.hour_t),
    .ALM_10     (tb_bus.alm_time.hour_u),
    .ALM_M6     (tb_bus.alm_time.min_t),
    .ALM_M10    (tb_bus.alm_time.min_u),
    .ALARM_ON   (tb_bus.alarm_on),
    .STOP_BTN   (tb_bus.stop_btn),
    .SNOOZE_BTN (tb_bus.snooze_btn),
    .BUZZ       (buzz),
    .RINGING    (ringing),
    .SNOOZING   (snoozing)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int minutes_of(input bcd_time_t t);
    return (int'(t.hour_t) * 10 + int'(t.hour_u)) * 60 + int'(t.min_t) * 10 + int'(t.min_u);
  endfunction

  task automatic set_time(input int hh, input int mm);
    tb_bus.now_time.hour_t = 2'(hh / 10);
    tb_bus.now_time.hour_u = 4'(hh % 10);
    tb_bus.now_time.min_t  = 3'(mm / 10);
    tb_bus.now_time.min_u  = 4'(mm % 10);
  endtask

  task automatic set_alarm(input int hh, input int mm);
    tb_bus.alm_time.hour_t = 2'(hh / 10);
    tb_bus.alm_time.hour_u = 4'(hh % 10);
    tb_bus.alm_time.min_t  = 3'(mm / 10);
    tb_bus.alm_time.min_u  = 4'(mm % 10);
  endtask

  task automatic model_reset();
    m_mode       = M_IDLE;
    m_ring_secs  = 0;
    m_snz_secs   = 0;
    m_prev_match = 1'b1;
  endtask

  // Advance the model by one clock using the inputs the DUT sees at this edge.
  task automatic model_step();
    bit now_match;
    bit trig;
    if (!RESET_N) begin
      model_reset();
      return;
    end
    now_match    = (minutes_of(tb_bus.now_time) == minutes_of(tb_bus.alm_time));
    trig         = now_match && !m_prev_match && tb_bus.alarm_on;
    m_prev_match = now_match;
    case (m_mode)
      M_IDLE: begin
        if (trig) begin
          m_mode      = M_RING;
          m_ring_secs = 0;
        end
      end
      M_RING: begin
        if (tb_bus.stop_btn || !tb_bus.alarm_on) begin
          m_mode = M_IDLE;
        end else if (SNOOZE_BUILD && tb_bus.snooze_btn) begin
          m_mode     = M_SNOOZE;
          m_snz_secs = 0;
        end else if (tb_bus.sec_en) begin
          m_ring_secs++;
          if (m_ring_secs == RING_SEC) m_mode = M_IDLE;
        end
      end
      default: begin
        if (tb_bus.stop_btn || !tb_bus.alarm_on) begin
          m_mode = M_IDLE;
        end else if (trig) begin
          m_mode      = M_RING;
          m_ring_secs = 0;
        end else if (tb_bus.sec_en) begin
          m_snz_secs++;
          if (m_snz_secs == SNOOZE_SEC) begin
            m_mode      = M_RING;
            m_ring_secs = 0;
          end
        end
      end
    endcase
  endtask

  // One clock: model update on the edge, output check 1 time unit later.
  task automatic run_cycle(input string tag);
    int exp_ring;
    int exp_buzz;
    int exp_snz;
    @(posedge CLK);
    model_step();
    #1;
    exp_ring = (m_mode == M_RING) ? 1 : 0;
    exp_buzz = (m_mode == M_RING && (m_ring_secs % 2) == 0) ? 1 : 0;
    exp_snz  = (m_mode == M_SNOOZE) ? 1 : 0;
    check_val($sformatf("%s.buzz", tag), int'(buzz), exp_buzz);
    check_val($sformatf("%s.ringing", tag), int'(ringing), exp_ring);
    check_val($sformatf("%s.snoozing", tag), int'(snoozing), exp_snz);
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) run_cycle(tag);
  endtask

  task automatic sec_pulses(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tb_bus.sec_en = 1'b1;
      run_cycle(tag);
      tb_bus.sec_en = 1'b0;
      idle_cycles(int'($urandom_range(0, 2)), tag);
    end
  endtask

  task automatic press(input bit stop, input bit snooze, input string tag);
    tb_bus.stop_btn   = stop;
    tb_bus.snooze_btn = snooze;
    run_cycle(tag);
    tb_bus.stop_btn   = 1'b0;
    tb_bus.snooze_btn = 1'b0;
  endtask

  // Call right after run_cycle: asserts reset between edges and checks outputs
  // clear before the next clock edge.
  task automatic async_reset(input string tag);
    #2 RESET_N = 1'b0;
    #1;
    check_val($sformatf("%s.async_buzz", tag), int'(buzz), 0);
    check_val($sformatf("%s.async_ringing", tag), int'(ringing), 0);
    check_val($sformatf("%s.async_snoozing", tag), int'(snoozing), 0);
    model_reset();
    idle_cycles(2, tag);
    RESET_N = 1'b1;
  endtask

  initial begin
    RESET_N           = 1'b1;
    tb_bus.sec_en     = 1'b0;
    tb_bus.alarm_on   = 1'b1;
    tb_bus.stop_btn   = 1'b0;
    tb_bus.snooze_btn = 1'b0;
    set_time(6, 59);
    set_alarm(7, 0);
    model_reset();

    #1 RESET_N = 1'b0;
    #1;
    check_val("reset.buzz", int'(buzz), 0);
    check_val("reset.ringing", int'(ringing), 0);
    check_val("reset.snoozing", int'(snoozing), 0);
    idle_cycles(3, "reset_hold");
    RESET_N = 1'b1;
    $display("TXN reset released at 06:59, alarm 07:00");

    idle_cycles(3, "pre_0700");
    set_time(7, 0);
    run_cycle("trigger_0700");
    sec_pulses(RING_SEC, "ring_auto_stop");
    idle_cycles(20, "no_retrigger");
    $display("TXN 07:00 ring ran to auto-stop");

    set_alarm(8, 0);
    set_time(7, 59);
    idle_cycles(2, "pre_0800");
    set_time(8, 0);
    run_cycle("trigger_0800");
    sec_pulses(10, "ring_before_snooze");
    press(1'b0, 1'b1, "snooze_press");
    idle_cycles(3, "snooze_wait");
    sec_pulses(SNOOZE_SEC, "snooze_count");
    idle_cycles(2, "after_snooze");
    press(1'b1, 1'b0, "stop_press");
    idle_cycles(2, "after_stop");
    $display("TXN snooze sequence at 08:00 (snooze build=%0d)", SNOOZE_BUILD);

    set_alarm(8, 2);
    set_time(8, 1);
    idle_cycles(2, "pre_0802");
    set_time(8, 2);
    run_cycle("trigger_0802");
    sec_pulses(3, "ring_0802");
    press(1'b1, 1'b1, "stop_and_snooze");
    idle_cycles(3, "after_both");
    $display("TXN stop+snooze together at 08:02");

    tb_bus.alarm_on = 1'b0;
    set_alarm(12, 30);
    set_time(12, 30);
    idle_cycles(3, "off_in_match");
    tb_bus.alarm_on = 1'b1;
    idle_cycles(5, "on_mid_match");
    set_alarm(12, 32);
    set_time(12, 31);
    idle_cycles(2, "pre_1232");
    set_time(12, 32);
    run_cycle("trigger_1232");
    sec_pulses(4, "ring_1232");
    tb_bus.alarm_on = 1'b0;
    run_cycle("switch_off");
    idle_cycles(2, "after_off");
    tb_bus.alarm_on = 1'b1;
    $display("TXN ALARM_ON gating at 12:30 / 12:32");

    set_alarm(7, 0);
    set_time(6, 59);
    idle_cycles(2, "pre_reset_ring");
    set_time(7, 0);
    run_cycle("trigger_reset_ring");
    sec_pulses(5, "ring_before_reset");
    async_reset("reset_mid_ring");
    idle_cycles(10, "after_reset_ring");
    $display("TXN reset mid-ring at 07:00");

    set_time(6, 58);
    idle_cycles(2, "pre_reset_snooze");
    set_time(7, 0);
    run_cycle("trigger_reset_snooze");
    press(1'b0, 1'b1, "snooze_before_reset");
    sec_pulses(5, "snooze_before_reset");
    async_reset("reset_mid_snooze");
    idle_cycles(10, "after_reset_snooze");
    $display("TXN reset mid-snooze at 07:00");

    set_alarm(10, 30);
    set_time(10, 29);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) set_time(10, 29 + int'($urandom_range(0, 2)));
      if ($urandom_range(0, 199) == 0) set_alarm(10, 30 + int'($urandom_range(0, 1)));
      if ($urandom_range(0, 149) == 0) tb_bus.alarm_on = ~tb_bus.alarm_on;
      tb_bus.sec_en     = ($urandom_range(0, 2) == 0);
      tb_bus.stop_btn   = ($urandom_range(0, 399) == 0);
      tb_bus.snooze_btn = ($urandom_range(0, 59) == 0);
      run_cycle("random");
    end
    tb_bus.sec_en     = 1'b0;
    tb_bus.stop_btn   = 1'b0;
    tb_bus.snooze_btn = 1'b0;
    $display("TXN 4000 random cycles around 10:30");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alarm_match.md
ALARM_MATCH -- requirements
Module: alarm_match

Interface
REQ-001 SHALL have parameter RING_SEC, default 60, ring duration in seconds before auto-stop (1..255).
REQ-002 SHALL have parameter SNOOZE_SEC, default 300, snooze delay in seconds (1..1023).
REQ-003 SHALL have port CLK  input  1  system clock; all state on posedge.
REQ-004 SHALL have port RESET_N  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port SEC_EN  input  1  one-CLK pulse per second.
REQ-006 SHALL have ports HOUR_2/HOUR_10/MIN_6/MIN_10  input  2/4/3/4  current time, BCD (tens/units).
REQ-007 SHALL have ports ALM_2/ALM_10/ALM_M6/ALM_M10  input  2/4/3/4  alarm setting, BCD, same encoding.
REQ-008 SHALL have port ALARM_ON  input  1  alarm enable switch, level.
REQ-009 SHALL have port STOP_BTN  input  1  one-CLK debounced pulse, stop alarm.
REQ-010 SHALL have port SNOOZE_BTN  input  1  one-CLK debounced pulse, snooze.
REQ-011 SHALL have port BUZZ  output  1  buzzer drive, registered.
REQ-012 SHALL have port RINGING  output  1  high in RING state, registered.
REQ-013 SHALL have port SNOOZING  output  1  high in SNOOZE state, registered.

Function
REQ-014 SHALL compute MATCH combinationally when all 13 time bits equal all 13 alarm bits (seconds not compared).
REQ-015 SHALL register MATCH into match_q every CLK; trigger = MATCH & ~match_q & ALARM_ON (rising edge only; enabling ALARM_ON mid-match minute does not ring).
REQ-016 SHALL implement FSM states IDLE, RING, SNOOZE.
REQ-017 IDLE -> RING on trigger; ring counter and beep phase cleared to 0, BUZZ=1 on next CLK.
REQ-018 RING: ring counter increments on SEC_EN; BUZZ toggles on each SEC_EN (1 s on / 1 s off).
REQ-019 RING -> IDLE on STOP_BTN, on ALARM_ON=0, or on SEC_EN when ring counter = RING_SEC-1; BUZZ=0 next CLK.
REQ-020 RING -> SNOOZE on SNOOZE_BTN; snooze counter cleared; BUZZ=0.
REQ-021 SNOOZE: snooze counter increments on SEC_EN; on SEC_EN with counter = SNOOZE_SEC-1 -> RING (counters cleared, BUZZ=1).
REQ-022 SNOOZE -> IDLE on STOP_BTN or ALARM_ON=0.
REQ-023 STOP_BTN and SNOOZE_BTN in same CLK: STOP wins.
REQ-024 Trigger during SNOOZE: -> RING immediately, snooze cancelled.
REQ-025 Trigger during RING: ignored; ring counter not restarted.
REQ-026 Alarm setting changes during RING/SNOOZE: no effect on current state.
REQ-027 Counter widths SHALL be $clog2 of the parameter; counters saturate-free, cleared on every state entry.

Reset
REQ-028 RESET_N=0 SHALL asynchronously force IDLE, BUZZ=0, RINGING=0, SNOOZING=0, counters=0, match_q=1 (no ring if reset released during match minute).
REQ-029 Reset mid-RING or mid-SNOOZE SHALL abandon the alarm; no resumption after release.

Configuration
REQ-030 Macro ALARM_SNOOZE_EN defined: SNOOZE state, snooze counter and SNOOZING per REQ-020..022.
REQ-031 ALARM_SNOOZE_EN undefined: no SNOOZE state or counter; SNOOZE_BTN ignored; SNOOZING tied 0; port list unchanged.

Structure
REQ-032 Shared package clock_pkg SHALL hold the FSM state typedef (IDLE, RING, SNOOZE) and BCD field width constants.
REQ-033 Sub-module sec_counter (parameterised modulo counter, SEC_EN enable, clear, terminal-count flag) SHALL be instantiated for ring and snooze counters.

Verification
REQ-034 Time 06:59->07:00, alarm 07:00, ALARM_ON=1 -> RINGING=1 and BUZZ=1 one CLK after edge; BUZZ toggles each SEC_EN.
REQ-035 Ring with no buttons -> RINGING falls on 60th SEC_EN; no re-trigger while time stays 07:00.
REQ-036 SNOOZE_BTN at 10 s -> SNOOZING=1, BUZZ=0; RINGING=1 again on 300th SEC_EN (macro defined); SNOOZE_BTN has no effect (macro undefined).
REQ-037 STOP_BTN and SNOOZE_BTN same CLK during RING -> IDLE, SNOOZING=0.
REQ-038 ALARM_ON raised while time=alarm=12:30 -> no ring; ALARM_ON=0 during RING -> IDLE next CLK.
REQ-039 RESET_N pulsed low mid-RING at 07:00 -> all outputs 0 asynchronously; no ring after release within same minute.
